// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - shared CRC-32 constants and the single-bit serial step
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'h38FB2284;

  // One serial step in normal (MSB-shifting) form; the wire bit enters at the top.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic        b,
                                             input logic [31:0] poly);
    logic fb;
    fb = crc[31] ^ b;
    return {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - Ethernet CRC-32 engine absorbing one RMII dibit per clock
module crc32_dibit
  import crc32_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY,
  parameter logic [31:0] INIT = CRC32_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic [31:0] axiod
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // axiid[0] is earlier on the wire, so it is stepped in first.
  always_comb begin
    crc_d = crc_q;
    if (axiiv) begin
      crc_d = crc32_step(crc32_step(crc_q, axiid[0], POLY), axiid[1], POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign axiod = ~crc_q;

endmodule

// File: tb/tb_crc32_dibit.sv
// tb/tb_crc32_dibit.sv - directed and reference-model bench for crc32_dibit
module tb_crc32_dibit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;
  logic [31:0] axiod;

  int checks = 0;
  int errors = 0;

  // Reference register kept in reflected (LSB-shifting) form.
  logic [31:0] m_r = 32'hFFFFFFFF;

  crc32_dibit dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiod (axiod)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  function automatic logic [31:0] model_out();
    return bitrev32(~m_r);
  endfunction

  task automatic drive(input logic v, input logic [1:0] d);
    @(negedge clk);
    axiiv = v;
    axiid = d;
    @(posedge clk);
    if (!rst) begin
      m_r = 32'hFFFFFFFF;
    end else if (v) begin
      for (int i = 0; i < 2; i++)
        m_r = (m_r >> 1) ^ (((m_r[0] ^ d[i]) != 1'b0) ? 32'hEDB88320 : 32'h0);
    end
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gapped);
    for (int k = 0; k < 4; k++) begin
      if (gapped) begin
        int n;
        n = $urandom_range(1, 5);
        for (int g = 0; g < n; g++) drive(1'b0, 2'b00);
      end
      drive(1'b1, b[2*k +: 2]);
    end
  endtask

  task automatic send_check_string(input bit gapped, input bit flip);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'h31 + 8'(i);
      if (flip && i == 0) b = b ^ 8'h01;
      send_byte(b, gapped);
    end
  endtask

  task automatic send_fcs(input bit gapped);
    send_byte(8'h26, gapped);
    send_byte(8'h39, gapped);
    send_byte(8'hF4, gapped);
    send_byte(8'hCB, gapped);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (axiod !== 32'h00000000) begin
      errors++;
      $display("FAIL reset_value got %08h want %08h", axiod, 32'h00000000);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b11);
      checks++;
      if (axiod !== 32'h00000000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got %08h want %08h", i, axiod, 32'h00000000);
      end
    end
  endtask

  task automatic test_check_vector();
    apply_reset();
    send_check_string(1'b0, 1'b0);
    checks++;
    if (axiod !== 32'h649C2FD3) begin
      errors++;
      $display("FAIL check_vector got %08h want %08h", axiod, 32'h649C2FD3);
    end
    drive(1'b0, 2'b10);
    checks++;
    if (axiod !== 32'h649C2FD3) begin
      errors++;
      $display("FAIL check_vector_hold got %08h want %08h", axiod, 32'h649C2FD3);
    end
  endtask

  task automatic test_residue();
    apply_reset();
    send_check_string(1'b0, 1'b0);
    send_fcs(1'b0);
    checks++;
    if (axiod !== 32'h38FB2284) begin
      errors++;
      $display("FAIL residue got %08h want %08h", axiod, 32'h38FB2284);
    end
  endtask

  task automatic test_bitflip();
    apply_reset();
    send_check_string(1'b0, 1'b1);
    send_fcs(1'b0);
    checks++;
    if (axiod === 32'h38FB2284) begin
      errors++;
      $display("FAIL bitflip_residue got %08h want not %08h", axiod, 32'h38FB2284);
    end
    checks++;
    if (axiod !== model_out()) begin
      errors++;
      $display("FAIL bitflip_model got %08h want %08h", axiod, model_out());
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    send_check_string(1'b1, 1'b0);
    checks++;
    if (axiod !== 32'h649C2FD3) begin
      errors++;
      $display("FAIL gapped_check got %08h want %08h", axiod, 32'h649C2FD3);
    end
    send_fcs(1'b1);
    checks++;
    if (axiod !== 32'h38FB2284) begin
      errors++;
      $display("FAIL gapped_residue got %08h want %08h", axiod, 32'h38FB2284);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hF0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 2'b11);
    rst = 1'b1;
    checks++;
    if (axiod !== 32'h00000000) begin
      errors++;
      $display("FAIL midstream_reset got %08h want %08h", axiod, 32'h00000000);
    end
    send_check_string(1'b0, 1'b0);
    checks++;
    if (axiod !== 32'h649C2FD3) begin
      errors++;
      $display("FAIL midstream_check got %08h want %08h", axiod, 32'h649C2FD3);
    end
  endtask

  task automatic test_random_model();
    for (int f = 0; f < 2; f++) begin
      logic [7:0]  frame [68];
      logic [31:0] fcs;
      int          bad;
      apply_reset();
      bad = 0;
      for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
      for (int i = 0; i < 68; i++) begin
        if (i == 64) begin
          fcs = ~m_r;
          frame[64] = fcs[7:0];
          frame[65] = fcs[15:8];
          frame[66] = fcs[23:16];
          frame[67] = fcs[31:24];
        end
        for (int k = 0; k < 4; k++) begin
          drive(1'b1, frame[i][2*k +: 2]);
          checks++;
          if (axiod !== model_out()) begin
            errors++;
            if (bad < 4)
              $display("FAIL model frame %0d byte %0d dibit %0d got %08h want %08h",
                       f, i, k, axiod, model_out());
            bad++;
          end
        end
      end
      checks++;
      if (axiod !== 32'h38FB2284) begin
        errors++;
        $display("FAIL model_residue frame %0d got %08h want %08h", f, axiod, 32'h38FB2284);
      end
    end
  endtask

  initial begin
    test_reset();
    test_check_vector();
    test_residue();
    test_bitflip();
    test_gapped();
    test_reset_midstream();
    test_random_model();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
